// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle control sequencer for an RV32I core. Each
//               instruction passes through FETCH, DECODE, EXEC, MEM (loads
//               and stores only) and WB (non-branch, non-store only). The
//               block runs the req/ack handshakes to instruction and data
//               memory, pulses the IR/PC/register-file write strobes, selects
//               the next-PC source, counts retired instructions and traps on
//               illegal opcodes.
//
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               instr        - instruction read data (valid with imem_ack)
//               imem_ack     - instruction memory acknowledge
//               dmem_ack     - data memory acknowledge
//               branch_taken - branch comparator result, sampled in EXEC
//               trap_clr     - leaves TRAP and restarts at FETCH
//               imem_req     - instruction fetch request
//               dmem_req     - data access request
//               dmem_we      - 1 = store, 0 = load (while dmem_req=1)
//               ir_write     - IR load strobe
//               pc_write     - PC update strobe
//               pc_sel       - 0 = PC+4, 1 = PC+imm, 2 = rs1+imm
//               reg_write    - register file write strobe
//               mem_to_reg   - WB source: 1 = load data, 0 = ALU result
//               retire       - one-cycle pulse per completed instruction
//               instret      - retired-instruction count (wraps)
//               trap         - sticky trap flag
//               trap_cause   - 1 = illegal opcode, 2 = memory timeout
//
// Build option: MULTICYCLE_CTRL_TIMEOUT_EN - when defined, an 8-bit wait
//               counter traps (cause 2) after TIMEOUT_CYCLES unacknowledged
//               request cycles in FETCH or MEM. When undefined the FSM waits
//               indefinitely for an ack.
//
// Revision    : 1.0 - initial release
// ============================================================================

module multicycle_ctrl_fsm #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    // ------------------------------------------------------------------------
    // Opcode and encoding constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_op_alu    = 7'b0110011;
    localparam logic [6:0] c_op_alui   = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [1:0] c_pc_plus4  = 2'd0;
    localparam logic [1:0] c_pc_imm    = 2'd1;
    localparam logic [1:0] c_pc_rs1imm = 2'd2;

    localparam logic [1:0] c_cause_none    = 2'd0;
    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_timeout = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [6:0]       r_opcode;
    logic             r_active;
    logic [CNT_W-1:0] r_instret;
    logic [1:0]       r_trap_cause;
    logic [1:0]       w_cause_set;
    logic             w_timeout;

    logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_legal;

    // Only the opcode field matters to the sequencer.
    logic w_unused_instr;
    assign w_unused_instr = ^instr[31:7];

    assign w_is_load   = (r_opcode == c_op_load);
    assign w_is_store  = (r_opcode == c_op_store);
    assign w_is_branch = (r_opcode == c_op_branch);
    assign w_is_jal    = (r_opcode == c_op_jal);
    assign w_is_jalr   = (r_opcode == c_op_jalr);
    assign w_legal     = (r_opcode == c_op_alu)   || (r_opcode == c_op_alui)  ||
                         w_is_load || w_is_store  || w_is_branch || w_is_jal ||
                         w_is_jalr || (r_opcode == c_op_lui) ||
                         (r_opcode == c_op_auipc);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_active holds imem_req low from reset release until the first clock
    // edge, so the first fetch request appears in the first full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode.
    // Requests are pure state decodes. The strobes that complete a handshake
    // (ir_write, and the store's pc_write/retire) are qualified by the ack of
    // that same cycle, and the branch PC select follows branch_taken, because
    // those events must land in the cycle the condition is seen.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cause_set  = c_cause_none;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = c_pc_plus4;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        retire       = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (r_active) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write     = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_timeout) begin
                        w_cause_set  = c_cause_timeout;
                        w_state_next = S_TRAP;
                    end
                end
            end

            S_DECODE: begin
                if (w_legal) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_cause_set  = c_cause_illegal;
                    w_state_next = S_TRAP;
                end
            end

            S_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_state_next = S_MEM;
                end else if (w_is_branch) begin
                    pc_write     = 1'b1;
                    pc_sel       = branch_taken ? c_pc_imm : c_pc_plus4;
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_WB;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack) begin
                    if (w_is_store) begin
                        pc_write     = 1'b1;
                        retire       = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_cause_set  = c_cause_timeout;
                    w_state_next = S_TRAP;
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = w_is_load;
                pc_write     = 1'b1;
                retire       = 1'b1;
                w_state_next = S_FETCH;
                if (w_is_jal) begin
                    pc_sel = c_pc_imm;
                end else if (w_is_jalr) begin
                    pc_sel = c_pc_rs1imm;
                end
            end

            S_TRAP: begin
                if (trap_clr) begin
                    w_state_next = S_FETCH;
                end
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Opcode latch, retired-instruction counter, trap cause
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 7'd0;
        end else if (ir_write) begin
            r_opcode <= instr[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_cause <= c_cause_none;
        end else if (w_cause_set != c_cause_none) begin
            r_trap_cause <= w_cause_set;
        end else if (r_state == S_TRAP && trap_clr) begin
            r_trap_cause <= c_cause_none;
        end
    end

    // ------------------------------------------------------------------------
    // Optional memory-ack timeout
    // ------------------------------------------------------------------------
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait;

    // Cleared on every state change, so it restarts on entry to FETCH/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 8'd0;
        end else if (w_state_next != r_state) begin
            r_wait <= 8'd0;
        end else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // True during the TIMEOUT_CYCLES-th consecutive unacknowledged cycle.
    assign w_timeout = (r_wait == c_timeout_last);
`else
    assign w_timeout = 1'b0;
`endif

    assign instret    = r_instret;
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Directed self-checking bench for multicycle_ctrl_fsm. Inputs
//               change just after the falling edge; outputs are checked 1 ns
//               later, well away from the rising edge. The DUT is built with
//               CNT_W=4 so the instret wrap is reachable, and TIMEOUT_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             imem_ack, dmem_ack, branch_taken, trap_clr;
    logic             imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]       pc_sel;
    logic             reg_write, mem_to_reg, retire, trap;
    logic [CNT_W-1:0] instret;
    logic [1:0]       trap_cause;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_ctrl_fsm #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .trap_clr     (trap_clr),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .retire       (retire),
        .instret      (instret),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    // Output bundle: imem dmem we irw pcw sel[1:0] rw m2r ret trap cause[1:0]
    logic [12:0] obs;
    assign obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
                  reg_write, mem_to_reg, retire, trap, trap_cause};

    localparam logic [12:0] X_IDLE    = 13'b0_0_0_0_0_00_0_0_0_0_00;
    localparam logic [12:0] X_FREQ    = 13'b1_0_0_0_0_00_0_0_0_0_00;
    localparam logic [12:0] X_FACK    = 13'b1_0_0_1_0_00_0_0_0_0_00;
    localparam logic [12:0] X_WB_ALU  = 13'b0_0_0_0_1_00_1_0_1_0_00;
    localparam logic [12:0] X_WB_LD   = 13'b0_0_0_0_1_00_1_1_1_0_00;
    localparam logic [12:0] X_WB_JAL  = 13'b0_0_0_0_1_01_1_0_1_0_00;
    localparam logic [12:0] X_WB_JALR = 13'b0_0_0_0_1_10_1_0_1_0_00;
    localparam logic [12:0] X_LD_MEM  = 13'b0_1_0_0_0_00_0_0_0_0_00;
    localparam logic [12:0] X_ST_ACK  = 13'b0_1_1_0_1_00_0_0_1_0_00;
    localparam logic [12:0] X_BR_T    = 13'b0_0_0_0_1_01_0_0_1_0_00;
    localparam logic [12:0] X_BR_NT   = 13'b0_0_0_0_1_00_0_0_1_0_00;
    localparam logic [12:0] X_TRAP1   = 13'b0_0_0_0_0_00_0_0_0_1_01;
    localparam logic [12:0] X_TRAP2   = 13'b0_0_0_0_0_00_0_0_0_1_10;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock: drive inputs just after the falling edge, then settle.
    task automatic step(input logic ia, input logic da, input logic bt,
                        input logic tc, input logic [31:0] iw);
        @(negedge clk);
        instr        = iw;
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = bt;
        trap_clr     = tc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; trap_clr = 1'b0;

        // Reset state
        step(1, 1, 0, 0, I_ADDI);
        chk("rst_outputs", 32'(obs), 32'(X_IDLE));
        chk("rst_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;

        // 1: addi, ack on first request cycle; acks/trap_clr in DECODE ignored
        step(1, 0, 0, 0, I_ADDI);  chk("t1_fetch",  32'(obs), 32'(X_FACK));
        step(1, 1, 0, 1, 32'd0);   chk("t1_decode", 32'(obs), 32'(X_IDLE));
        step(0, 0, 0, 0, 32'd0);   chk("t1_exec",   32'(obs), 32'(X_IDLE));
        step(0, 0, 0, 0, 32'd0);   chk("t1_wb",     32'(obs), 32'(X_WB_ALU));
        chk("t1_instret_pre", 32'(instret), 32'd0);

        // 2: load, dmem_ack after 3 wait cycles (8 cycles total)
        step(1, 0, 0, 0, I_LW);    chk("t2_fetch",  32'(obs), 32'(X_FACK));
        chk("t1_instret", 32'(instret), 32'd1);
        step(0, 0, 0, 0, 32'd0);   chk("t2_decode", 32'(obs), 32'(X_IDLE));
        step(0, 0, 0, 0, 32'd0);   chk("t2_exec",   32'(obs), 32'(X_IDLE));
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 32'd0); chk("t2_mem_wait", 32'(obs), 32'(X_LD_MEM));
        end
        step(1, 1, 0, 0, 32'd0);   chk("t2_mem_ack", 32'(obs), 32'(X_LD_MEM));
        step(0, 0, 0, 0, 32'd0);   chk("t2_wb",     32'(obs), 32'(X_WB_LD));

        // 3: taken beq, then store
        step(1, 0, 0, 0, I_BEQ);   chk("t3_br_fetch", 32'(obs), 32'(X_FACK));
        chk("t2_instret", 32'(instret), 32'd2);
        step(0, 0, 0, 0, 32'd0);   chk("t3_br_decode", 32'(obs), 32'(X_IDLE));
        step(0, 0, 1, 0, 32'd0);   chk("t3_br_exec",  32'(obs), 32'(X_BR_T));
        step(1, 0, 0, 0, I_SW);    chk("t3_st_fetch", 32'(obs), 32'(X_FACK));
        step(0, 0, 0, 0, 32'd0);   chk("t3_st_decode", 32'(obs), 32'(X_IDLE));
        step(0, 0, 0, 0, 32'd0);   chk("t3_st_exec",  32'(obs), 32'(X_IDLE));
        step(0, 1, 0, 0, 32'd0);   chk("t3_st_mem",   32'(obs), 32'(X_ST_ACK));

        // Not-taken branch, jal and jalr PC selects
        step(1, 0, 0, 0, I_BEQ);   chk("nt_fetch", 32'(obs), 32'(X_FACK));
        chk("t3_instret", 32'(instret), 32'd4);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);   chk("nt_exec", 32'(obs), 32'(X_BR_NT));
        step(1, 0, 0, 0, I_JAL);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);   chk("jal_wb", 32'(obs), 32'(X_WB_JAL));
        step(1, 0, 0, 0, I_JALR);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);   chk("jalr_wb", 32'(obs), 32'(X_WB_JALR));

        // 4: illegal opcode, 10 trap cycles, trap_clr restarts fetch
        step(1, 0, 0, 0, I_ILL);   chk("t4_fetch", 32'(obs), 32'(X_FACK));
        chk("t4_instret", 32'(instret), 32'd7);
        step(0, 0, 0, 0, 32'd0);   chk("t4_decode", 32'(obs), 32'(X_IDLE));
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 1, 0, 32'd0); chk("t4_trap_hold", 32'(obs), 32'(X_TRAP1));
        end
        step(0, 0, 0, 1, 32'd0);   chk("t4_trap_clr", 32'(obs), 32'(X_TRAP1));
        step(0, 0, 0, 0, 32'd0);   chk("t4_refetch", 32'(obs), 32'(X_FREQ));
        chk("t4_instret_hold", 32'(instret), 32'd7);

        // 5: ten more ALU ops -> 17 retired, 4-bit counter wraps to 1
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0, I_ADDI); chk("t5_fetch", 32'(obs), 32'(X_FACK));
            chk("t5_instret", 32'(instret), 32'((7 + k) % 16));
            step(0, 0, 0, 0, 32'd0);
            step(0, 0, 0, 0, 32'd0);
            step(0, 0, 0, 0, 32'd0); chk("t5_wb", 32'(obs), 32'(X_WB_ALU));
        end
        step(0, 0, 0, 0, 32'd0);   chk("t5_instret_wrap", 32'(instret), 32'd1);

        // 6: reset asserted while a load waits in MEM
        step(1, 0, 0, 0, I_LW);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);   chk("t6_mem", 32'(obs), 32'(X_LD_MEM));
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 32'(obs), 32'(X_IDLE));
        chk("t6_instret", 32'(instret), 32'd0);
        step(1, 1, 0, 0, 32'd0);   chk("t6_in_reset", 32'(obs), 32'(X_IDLE));
        rst_n = 1'b1;
        step(0, 0, 0, 0, 32'd0);   chk("t6_first_req", 32'(obs), 32'(X_FREQ));

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        // Fetch timeout after 4 unacknowledged request cycles
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 32'd0); chk("to_wait", 32'(obs), 32'(X_FREQ));
        end
        step(0, 0, 0, 0, 32'd0);   chk("to_trap", 32'(obs), 32'(X_TRAP2));
        step(0, 0, 0, 1, 32'd0);   chk("to_trap_clr", 32'(obs), 32'(X_TRAP2));
        step(0, 0, 0, 0, 32'd0);   chk("to_refetch", 32'(obs), 32'(X_FREQ));
`else
        // No timeout: fetch request holds indefinitely
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 0, 32'd0); chk("no_to_wait", 32'(obs), 32'(X_FREQ));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
